// File: rtl/uart_pkg.sv
// Shared UART constants and byte type for the transmit path.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_FRAME_LEN = 10;
    localparam int UART_STOP_SLOT = 9;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    function automatic uart_byte_t bit_reverse(input uart_byte_t b);
        uart_byte_t r;
        for (int i = 0; i < UART_DATA_W; i++) begin
            r[i] = b[UART_DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with a separately tracked level so full/empty never alias.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_baud,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  uart_byte_t    i_data,
    output uart_byte_t    o_data,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    uart_byte_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Room is judged on the registered level only; a same-cycle pop does not free a slot.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk_baud) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_baud or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and frame gate feeding a free-running 10-slot UART serializer.
// Optional build macro UART_TX_LSB_FIRST_EN loads bytes bit-reversed so bit 0 leaves first.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   clk_baud,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   ovf_clr,
    input  logic                   tx_done,
    input  logic                   data_serial,
    output logic [UART_DATA_W-1:0] data_byte,
    output logic                   frame_valid,
    output logic                   txd,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic                   overflow
);

    uart_byte_t r_data_byte;
    logic       r_frame_valid;
    logic       r_overflow;
    uart_byte_t w_head;
    uart_byte_t w_load;
    logic       w_pop;

    assign w_pop = tx_done && !empty;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_baud (clk_baud),
        .reset_n  (reset_n),
        .i_push   (wr_en),
        .i_pop    (w_pop),
        .i_data   (wr_data),
        .o_data   (w_head),
        .o_level  (level),
        .o_full   (full),
        .o_empty  (empty)
    );

`ifdef UART_TX_LSB_FIRST_EN
    assign w_load = bit_reverse(w_head);
`else
    assign w_load = w_head;
`endif

    // Decision register: only moves on the serializer's stop-slot edge, aligning with slot 0.
    always_ff @(posedge clk_baud or negedge reset_n) begin
        if (!reset_n) begin
            r_data_byte   <= '0;
            r_frame_valid <= 1'b0;
        end else if (tx_done) begin
            if (!empty) begin
                r_data_byte   <= w_load;
                r_frame_valid <= 1'b1;
            end else begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_baud or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (wr_en && full) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign data_byte   = r_data_byte;
    assign frame_valid = r_frame_valid;
    assign overflow    = r_overflow;
    assign txd         = r_frame_valid ? data_serial : 1'b1;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed scoreboard bench for uart_tx_feeder with a behavioural 10-slot serializer.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_baud = 1'b0;
    logic          reset_n  = 1'b0;
    logic          wr_en    = 1'b0;
    logic [7:0]    wr_data  = 8'h00;
    logic          ovf_clr  = 1'b0;
    logic          tx_done;
    logic          data_serial;
    logic [7:0]    data_byte;
    logic          frame_valid;
    logic          txd;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;

    logic          ser_run = 1'b1;
    logic [3:0]    slot;

    int            n_cmp = 0;
    int            n_err = 0;
    int            m_level = 0;
    logic [7:0]    exp_q[$];

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_baud    (clk_baud),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .ovf_clr     (ovf_clr),
        .tx_done     (tx_done),
        .data_serial (data_serial),
        .data_byte   (data_byte),
        .frame_valid (frame_valid),
        .txd         (txd),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clk_baud = ~clk_baud;

    // Serializer model: start bit, data_byte[7..0], stop bit; shares reset_n.
    always @(posedge clk_baud or negedge reset_n) begin
        if (!reset_n) slot <= 4'd0;
        else if (ser_run) slot <= (slot == 4'd9) ? 4'd0 : slot + 4'd1;
    end

    assign tx_done = ser_run && (slot == 4'd9);

    always_comb begin
        data_serial = 1'b1;
        if (slot == 4'd0) data_serial = 1'b0;
        else if (slot <= 4'd8) data_serial = data_byte[4'd8 - slot];
    end

    function automatic logic [7:0] exp_dbyte(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef UART_TX_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`endif
        return r;
    endfunction

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
`ifdef UART_TX_LSB_FIRST_EN
        return b[i-1];
`else
        return b[8-i];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_baud);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk_baud);
        #1;
        reset_n = 1'b1;
        m_level = 0;
        exp_q.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (m_level < DEPTH) begin
            exp_q.push_back(b);
            m_level++;
        end
    endtask

    task automatic wait_decision(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (slot != 4'd0 && n < 20);
        n_cmp++;
        assert (slot == 4'd0) else begin
            n_err++;
            $error("FAIL %s: observed no decision edge within %0d cycles expected one", tag, n);
        end
    endtask

    task automatic wait_slot9(input string tag);
        int n;
        n = 0;
        while (slot != 4'd9 && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (slot == 4'd9) else begin
            n_err++;
            $error("FAIL %s: observed slot %0d expected 9", tag, slot);
        end
    endtask

    // Called just after a decision edge; consumes the frame and ends after the next one.
    task automatic check_frame(input string tag);
        logic [7:0] b;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s sb: observed empty scoreboard expected a byte", tag);
        end
        b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        m_level--;
        chk({tag, " data_byte"}, data_byte, exp_dbyte(b));
        chk({tag, " frame_valid"}, frame_valid, 1'b1);
        chk({tag, " level"}, level, m_level);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s txd%0d", tag, i), txd, exp_bit(b, i));
            tick();
        end
    endtask

    initial begin
        logic [7:0] b;

        // Reset values
        #2;
        chk("rst txd", txd, 1'b1);
        chk("rst frame_valid", frame_valid, 1'b0);
        chk("rst data_byte", data_byte, 8'h00);
        chk("rst level", level, 0);
        chk("rst empty", empty, 1'b1);
        chk("rst full", full, 1'b0);
        chk("rst overflow", overflow, 1'b0);

        // Idle: 40 cycles of a high line
        release_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("idle txd", txd, 1'b1);
            chk("idle frame_valid", frame_valid, 1'b0);
            chk("idle empty", empty, 1'b1);
        end

        // Single byte written in cycle 3, loaded at cycle 10
        reset_n = 1'b0;
        repeat (2) @(posedge clk_baud);
        release_reset();
        tick();
        tick();
        write_byte(8'hA5);
        chk("a5 level", level, 1);
        repeat (6) tick();
        chk("a5 pre fv", frame_valid, 1'b0);
        chk("a5 pre txd", txd, 1'b1);
        tick();
        check_frame("a5");
        chk("a5 post fv", frame_valid, 1'b0);
        chk("a5 post txd", txd, 1'b1);

        // Three back-to-back frames
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        chk("b2b level", level, 3);
        wait_decision("b2b wait");
        check_frame("b2b f1");
        check_frame("b2b f2");
        check_frame("b2b f3");
        chk("b2b end fv", frame_valid, 1'b0);
        chk("b2b end level", level, 0);
        chk("b2b end empty", empty, 1'b1);

        // Overflow with the serializer paused so no pop intervenes
        ser_run = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_byte(8'h10 + 8'(i));
        chk("ovf full", full, 1'b1);
        chk("ovf level16", level, DEPTH);
        chk("ovf not yet", overflow, 1'b0);
        write_byte(8'hEE);
        chk("ovf set", overflow, 1'b1);
        chk("ovf level kept", level, DEPTH);
        wr_en = 1'b1; wr_data = 8'hEF; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("ovf set beats clr", overflow, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf cleared", overflow, 1'b0);
        ser_run = 1'b1;
        wait_decision("ovf wait");
        for (int i = 0; i < DEPTH; i++) check_frame($sformatf("ovf f%0d", i));
        chk("ovf end fv", frame_valid, 1'b0);
        chk("ovf end empty", empty, 1'b1);

        // Write exactly on a decision edge with an empty FIFO: no bypass
        wait_slot9("edge align");
        write_byte(8'h3C);
        chk("edge fv", frame_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("edge level", level, 1);
            chk("edge txd", txd, 1'b1);
            tick();
        end
        check_frame("edge");

        // Reset asserted in slot 4 of a live frame
        write_byte(8'h01);
        write_byte(8'h55);
        wait_decision("mid wait");
        b = exp_q.pop_front();
        m_level--;
        chk("mid data_byte", data_byte, exp_dbyte(b));
        chk("mid fv", frame_valid, 1'b1);
        chk("mid level", level, 1);
        repeat (4) tick();
        chk("mid slot4 txd", txd, exp_bit(b, 4));
        reset_n = 1'b0;
        #1;
        chk("mid rst txd", txd, 1'b1);
        chk("mid rst fv", frame_valid, 1'b0);
        chk("mid rst level", level, 0);
        chk("mid rst empty", empty, 1'b1);
        chk("mid rst data_byte", data_byte, 8'h00);
        release_reset();
        write_byte(8'h01);
        wait_decision("post wait");
        check_frame("post 01");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
